// File: rtl/mpu_transpose_sequencer.sv
// Stream-side sequencer for the 5x5 8-bit transpose datapath: loads 25 bytes row-major,
// runs one transpose/pass-through cycle, then drains 25 result bytes row-major.
module mpu_transpose_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]   state_r, state_nxt_s;
    logic [2:0]   row_r, col_r, row_nxt_s, col_nxt_s;
    logic         op_r, op_nxt_s;
    logic [199:0] matrix_r, matrix_nxt_s;
    logic [199:0] result_r, result_nxt_s;
    logic         in_ready_r, out_valid_r, busy_r, done_r;
    logic [7:0]   out_data_r, out_data_nxt_s;
    logic         done_nxt_s;
    logic         in_hs_s, out_hs_s, last_s;

    // Element (i,j) lives at bits [8*(i+5*j) +: 8]; result (i,j) takes source (j,i).
    function automatic logic [199:0] transpose5(input logic [199:0] m);
        logic [199:0] t;
        t = 200'd0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                t[8*(i+5*j) +: 8] = m[8*(j+5*i) +: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [7:0] elem_get(input logic [199:0] m, input logic [2:0] r,
                                            input logic [2:0] c);
        logic [7:0] e;
        e = 8'd0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if ((r == 3'(i)) && (c == 3'(j))) begin
                    e = m[8*(i+5*j) +: 8];
                end else begin
                    e = e;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [199:0] elem_put(input logic [199:0] m, input logic [2:0] r,
                                              input logic [2:0] c, input logic [7:0] v);
        logic [199:0] t;
        t = m;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if ((r == 3'(i)) && (c == 3'(j))) begin
                    t[8*(i+5*j) +: 8] = v;
                end else begin
                    t = t;
                end
            end
        end
        return t;
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state, counter, matrix and result computation.
    always_comb begin
        state_nxt_s    = state_r;
        row_nxt_s      = row_r;
        col_nxt_s      = col_r;
        op_nxt_s       = op_r;
        matrix_nxt_s   = matrix_r;
        result_nxt_s   = result_r;
        done_nxt_s     = 1'b0;
        out_data_nxt_s = 8'd0;
        in_hs_s  = (state_r == ST_LOAD) && in_ready_r && in_valid;
        out_hs_s = (state_r == ST_DRAIN) && out_valid_r && out_ready;
        last_s   = (row_r == 3'd4) && (col_r == 3'd4);

        if (in_hs_s || out_hs_s) begin
            if (col_r == 3'd4) begin
                col_nxt_s = 3'd0;
                row_nxt_s = (row_r == 3'd4) ? 3'd0 : row_r + 3'd1;
            end else begin
                col_nxt_s = col_r + 3'd1;
            end
        end else begin
            col_nxt_s = col_r;
        end

        case (state_r)
            ST_LOAD: begin
                if (in_hs_s) begin
                    matrix_nxt_s = elem_put(matrix_r, row_r, col_r, in_data);
                    op_nxt_s     = ((row_r == 3'd0) && (col_r == 3'd0)) ? in_op : op_r;
                    state_nxt_s  = last_s ? ST_EXEC : ST_LOAD;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_EXEC: begin
                result_nxt_s = op_r ? transpose5(matrix_r) : matrix_r;
                state_nxt_s  = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_hs_s && last_s) begin
                    state_nxt_s = ST_LOAD;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                row_nxt_s   = 3'd0;
                col_nxt_s   = 3'd0;
            end
        endcase

        if (state_nxt_s == ST_DRAIN) begin
            out_data_nxt_s = elem_get(result_nxt_s, row_nxt_s, col_nxt_s);
        end else begin
            out_data_nxt_s = 8'd0;
        end
    end

    // State and output registers; outputs are precomputed from next state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            row_r       <= 3'd0;
            col_r       <= 3'd0;
            op_r        <= 1'b0;
            matrix_r    <= 200'd0;
            result_r    <= 200'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_data_r  <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            row_r       <= row_nxt_s;
            col_r       <= col_nxt_s;
            op_r        <= op_nxt_s;
            matrix_r    <= matrix_nxt_s;
            result_r    <= result_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_LOAD);
            out_valid_r <= (state_nxt_s == ST_DRAIN);
            busy_r      <= (state_nxt_s != ST_LOAD);
            done_r      <= done_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

endmodule

// File: tb/tb_mpu_transpose_sequencer.sv
// Randomized self-checking bench for mpu_transpose_sequencer against a matrix-level model.
module tb_mpu_transpose_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_op = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, out_valid, busy, done;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [7:0] got[$];

    // Model: phase 0 = loading, 1 = executing, 2 = draining; cnt = flat row-major index.
    int         m_phase, m_cnt;
    bit         m_fresh, m_op, m_done;
    logic [7:0] m_mat[25];
    logic [7:0] m_res[25];

    always #5 clk = ~clk;

    mpu_transpose_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge, then compare against the DUT just after it.
    initial begin
        m_phase = 0; m_cnt = 0; m_fresh = 1'b1; m_op = 1'b0; m_done = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_cnt = 0; m_fresh = 1'b1; m_op = 1'b0; m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                case (m_phase)
                    0: if (!m_fresh && in_valid) begin
                        m_mat[m_cnt] = in_data;
                        if (m_cnt == 0) m_op = in_op;
                        m_cnt++;
                        if (m_cnt == 25) begin m_cnt = 0; m_phase = 1; end
                    end
                    1: begin
                        for (int k = 0; k < 25; k++)
                            m_res[k] = m_op ? m_mat[(k % 5) * 5 + k / 5] : m_mat[k];
                        m_phase = 2;
                    end
                    default: if (out_ready) begin
                        m_cnt++;
                        if (m_cnt == 25) begin m_cnt = 0; m_phase = 0; m_done = 1'b1; end
                    end
                endcase
                m_fresh = 1'b0;
            end
            #1;
            check("in_ready", in_ready, (m_phase == 0 && !m_fresh) ? 1 : 0);
            check("out_valid", out_valid, (m_phase == 2) ? 1 : 0);
            check("busy", busy, (m_phase != 0) ? 1 : 0);
            check("done", done, m_done);
            if (m_phase == 2) check("out_data", out_data, m_res[m_cnt]);
            if (done === 1'b1) done_count++;
        end
    end

    // Feed n bytes base, base+1, ...; element 0 carries op0, later bytes get op0 or random op.
    task automatic load(input int base, input int n, input bit op0, input bit gaps, input bit toggle);
        for (int k = 0; k < n; k++) begin
            int budget;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = 8'(base + k);
            in_op    = (k == 0) ? op0 : (toggle ? 1'($urandom_range(0, 1)) : op0);
            budget = 50;
            while (!in_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) check("load_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Accept n outputs; optionally stall 3 cycles at index stall_at, random out_ready, input pokes.
    task automatic drain(input int n, input int stall_at, input int stall_val, input bit rnd, input bit poke);
        int budget, stall_cnt;
        bit stalling;
        got.delete();
        budget = 2000;
        stall_cnt = 0;
        while (got.size() < n && budget > 0) begin
            stalling  = (stall_at >= 0) && (got.size() == stall_at) && (stall_cnt < 3);
            out_ready = stalling ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            in_valid  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = 8'($urandom);
            if (stalling && out_valid) begin
                stall_cnt++;
                check("stall_hold", out_data, stall_val);
            end
            if (out_valid && out_ready) got.push_back(out_data);
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 0, 1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic latency_check();
        check("exec_no_valid", out_valid, 0);
        check("exec_busy", busy, 1);
        @(negedge clk);
        check("drain_valid", out_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
    endtask

    initial begin
        int dc;
        @(negedge clk);
        do_reset();

        // Transpose of 1..25 with continuous streams.
        load(1, 25, 1'b1, 1'b0, 1'b0);
        latency_check();
        drain(25, -1, 0, 1'b0, 1'b0);
        check("t_out0", got[0], 1);
        check("t_out1", got[1], 6);
        check("t_out4", got[4], 21);
        check("t_out5", got[5], 2);
        check("t_out24", got[24], 25);
        check("t_ready_next", in_ready, 1);
        check("t_done_count", done_count, 1);

        // Pass-through with op toggling after element 0.
        load(1, 25, 1'b0, 1'b0, 1'b1);
        latency_check();
        drain(25, -1, 0, 1'b1, 1'b0);
        check("p_out0", got[0], 1);
        check("p_out7", got[7], 8);
        check("p_out24", got[24], 25);

        // Back-pressure at (2,3) with input pokes during drain.
        load(1, 25, 1'b1, 1'b0, 1'b0);
        latency_check();
        drain(25, 13, 18, 1'b0, 1'b1);
        check("bp_out12", got[12], 13);
        check("bp_out13", got[13], 18);
        check("bp_out14", got[14], 23);
        check("bp_count", got.size(), 25);

        // Random input gaps, large byte values.
        load(200, 25, 1'b1, 1'b1, 1'b1);
        latency_check();
        drain(25, -1, 0, 1'b1, 1'b0);
        check("g_out1", got[1], 205);
        check("g_out24", got[24], 224);

        // Reset mid-load, then mid-drain, then a clean transpose.
        dc = done_count;
        load(1, 12, 1'b1, 1'b1, 1'b0);
        do_reset();
        load(1, 25, 1'b1, 1'b0, 1'b0);
        latency_check();
        drain(7, -1, 0, 1'b0, 1'b0);
        do_reset();
        check("r_no_done", done_count, dc);
        load(1, 25, 1'b1, 1'b0, 1'b0);
        latency_check();
        drain(25, -1, 0, 1'b0, 1'b0);
        check("r_out1", got[1], 6);
        check("r_out24", got[24], 25);

        // Back-to-back matrices.
        dc = done_count;
        load(1, 25, 1'b1, 1'b0, 1'b0);
        latency_check();
        drain(25, -1, 0, 1'b0, 1'b0);
        check("b1_ready_next", in_ready, 1);
        load(101, 25, 1'b0, 1'b0, 1'b0);
        latency_check();
        drain(25, -1, 0, 1'b0, 1'b0);
        check("b2_ready_next", in_ready, 1);
        check("b2_out0", got[0], 101);
        check("b2_out24", got[24], 125);
        check("b_done_count", done_count, dc + 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
